// File: rtl/mem_loader_if.sv
// ============================================================================
// Module     : mem_loader_if
// Description: Bundle of the byte-stream input and the memory/CPU-control
//              outputs of mem_loader.
//              master : stream source / observer side (drives in_valid, in_data)
//              slave  : the loader itself (drives everything else)
//              Ports  : in_valid, in_data, in_ready, inst_we, inst_addr,
//                       inst_wdata, mem_we, mem_addr, mem_wdata, cpu_rstn,
//                       done, err
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_loader_if #(
  parameter int INST_LEN = 12,
  parameter int INST_CAP = 20,
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 8
);
  localparam int c_ia_w = $clog2(INST_CAP);

  logic                in_valid;
  logic [DATA_LEN-1:0] in_data;
  logic                in_ready;
  logic                inst_we;
  logic [c_ia_w-1:0]   inst_addr;
  logic [INST_LEN-1:0] inst_wdata;
  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic                cpu_rstn;
  logic                done;
  logic                err;

  modport master (
    output in_valid, in_data,
    input  in_ready, inst_we, inst_addr, inst_wdata,
           mem_we, mem_addr, mem_wdata, cpu_rstn, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, inst_we, inst_addr, inst_wdata,
           mem_we, mem_addr, mem_wdata, cpu_rstn, done, err
  );
endinterface

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module     : mem_loader
// Description: Boot-time loader. Parses framed records from a valid/ready
//              byte stream and writes instruction words and data bytes into
//              the CPU memories; holds the CPU in reset until a GO record.
//              Record: TYPE, START, COUNT, payload
//                0x01 instruction (COUNT words, 2 bytes each, high first)
//                0x02 data        (COUNT bytes)
//                0x03 GO          (no further bytes)
//              Ports  : clk, rst (async, active-high), bus (mem_loader_if.slave)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_loader #(
  parameter int INST_LEN = 12,
  parameter int INST_CAP = 20,
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 8,
  parameter int MEM_SIZE = 256
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_loader_if.slave  bus
);

  localparam int c_ia_w = $clog2(INST_CAP);
  // Address sum is one bit wider than a byte so START + index never wraps.
  localparam int c_sw   = DATA_LEN + 1;

  localparam logic [DATA_LEN-1:0] c_type_inst = DATA_LEN'(8'h01);
  localparam logic [DATA_LEN-1:0] c_type_data = DATA_LEN'(8'h02);
  localparam logic [DATA_LEN-1:0] c_type_go   = DATA_LEN'(8'h03);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_COUNT = 3'd2,
    S_IHI   = 3'd3,
    S_ILO   = 3'd4,
    S_DATA  = 3'd5,
    S_RUN   = 3'd6
  } state_t;

  // Registered state
  state_t              r_state;
  logic                r_is_inst;
  logic [DATA_LEN-1:0] r_start;
  logic [DATA_LEN-1:0] r_count;
  logic [DATA_LEN-1:0] r_idx;
  logic [DATA_LEN-1:0] r_hi;
  logic                r_ready;
  logic                r_inst_we;
  logic [c_ia_w-1:0]   r_inst_addr;
  logic [INST_LEN-1:0] r_inst_wdata;
  logic                r_mem_we;
  logic [ADDR_LEN-1:0] r_mem_addr;
  logic [DATA_LEN-1:0] r_mem_wdata;
  logic                r_cpu_rstn;
  logic                r_done;
  logic                r_err;

  // Next-state values
  state_t              w_state;
  logic                w_is_inst;
  logic [DATA_LEN-1:0] w_start;
  logic [DATA_LEN-1:0] w_count;
  logic [DATA_LEN-1:0] w_idx;
  logic [DATA_LEN-1:0] w_hi;
  logic                w_ready;
  logic                w_inst_we;
  logic [c_ia_w-1:0]   w_inst_addr;
  logic [INST_LEN-1:0] w_inst_wdata;
  logic                w_mem_we;
  logic [ADDR_LEN-1:0] w_mem_addr;
  logic [DATA_LEN-1:0] w_mem_wdata;
  logic                w_cpu_rstn;
  logic                w_done;
  logic                w_err;

  // Datapath helpers
  logic                w_accept;
  logic [c_sw-1:0]     w_sum;
  logic [c_sw-1:0]     w_idx_inc;
  logic                w_last;
  logic [INST_LEN-1:0] w_word;
  logic                w_inst_ok;
  logic                w_mem_ok;

  assign w_accept  = bus.in_valid && r_ready;
  assign w_sum     = {1'b0, r_start} + {1'b0, r_idx};
  assign w_idx_inc = {1'b0, r_idx} + c_sw'(1);
  assign w_last    = (w_idx_inc == {1'b0, r_count});
  assign w_word    = INST_LEN'({r_hi, bus.in_data});
  assign w_inst_ok = (w_sum < c_sw'(INST_CAP));
  assign w_mem_ok  = (w_sum < c_sw'(MEM_SIZE));

  always_comb begin
    w_state      = r_state;
    w_is_inst    = r_is_inst;
    w_start      = r_start;
    w_count      = r_count;
    w_idx        = r_idx;
    w_hi         = r_hi;
    w_inst_we    = 1'b0;
    w_inst_addr  = r_inst_addr;
    w_inst_wdata = r_inst_wdata;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_cpu_rstn   = r_cpu_rstn;
    w_done       = r_done;
    w_err        = r_err;

    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_data == c_type_inst) begin
            w_is_inst = 1'b1;
            w_state   = S_START;
          end else if (bus.in_data == c_type_data) begin
            w_is_inst = 1'b0;
            w_state   = S_START;
          end else if (bus.in_data == c_type_go) begin
            w_state    = S_RUN;
            w_done     = 1'b1;
            w_cpu_rstn = 1'b1;
          end else begin
            // Unknown type: flag and drop the byte, keep looking for a header.
            w_err = 1'b1;
          end
        end
        S_START: begin
          w_start = bus.in_data;
          w_state = S_COUNT;
        end
        S_COUNT: begin
          w_count = bus.in_data;
          w_idx   = '0;
          if (bus.in_data == '0) begin
            w_state = S_IDLE;
          end else begin
            w_state = r_is_inst ? S_IHI : S_DATA;
          end
        end
        S_IHI: begin
          w_hi    = bus.in_data;
          w_state = S_ILO;
        end
        S_ILO: begin
          // Out-of-range words are consumed but not written.
          if (w_inst_ok) begin
            w_inst_we    = 1'b1;
            w_inst_addr  = w_sum[c_ia_w-1:0];
            w_inst_wdata = w_word;
          end else begin
            w_err = 1'b1;
          end
          w_idx   = w_idx_inc[DATA_LEN-1:0];
          w_state = w_last ? S_IDLE : S_IHI;
        end
        S_DATA: begin
          if (w_mem_ok) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_sum[ADDR_LEN-1:0];
            w_mem_wdata = bus.in_data;
          end else begin
            w_err = 1'b1;
          end
          w_idx   = w_idx_inc[DATA_LEN-1:0];
          w_state = w_last ? S_IDLE : S_DATA;
        end
        default: begin
          // S_RUN is absorbing; r_ready is low there so nothing is accepted.
          w_state = r_state;
        end
      endcase
    end

    // Ready is registered from the next state so it drops with the GO edge.
    w_ready = (w_state != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_inst    <= 1'b0;
      r_start      <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_hi         <= '0;
      r_ready      <= 1'b0;
      r_inst_we    <= 1'b0;
      r_inst_addr  <= '0;
      r_inst_wdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rstn   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_is_inst    <= w_is_inst;
      r_start      <= w_start;
      r_count      <= w_count;
      r_idx        <= w_idx;
      r_hi         <= w_hi;
      r_ready      <= w_ready;
      r_inst_we    <= w_inst_we;
      r_inst_addr  <= w_inst_addr;
      r_inst_wdata <= w_inst_wdata;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_cpu_rstn   <= w_cpu_rstn;
      r_done       <= w_done;
      r_err        <= w_err;
    end
  end

  assign bus.in_ready   = r_ready;
  assign bus.inst_we    = r_inst_we;
  assign bus.inst_addr  = r_inst_addr;
  assign bus.inst_wdata = r_inst_wdata;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_rstn   = r_cpu_rstn;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// Module     : tb_mem_loader
// Description: Self-checking bench for mem_loader. Expected memory writes are
//              queued when a record is driven and popped by a write monitor.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_loader_if #(.INST_LEN(12), .INST_CAP(20), .DATA_LEN(8), .ADDR_LEN(8)) ifc ();

  mem_loader #(
    .INST_LEN(12), .INST_CAP(20), .DATA_LEN(8), .ADDR_LEN(8), .MEM_SIZE(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [31:0] inst_q[$];
  logic [31:0] mem_q[$];
  int          mem_stamp[$];
  logic [7:0]  bq[$];
  logic [31:0] mon_exp;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ip(input int a, input int d);
    return {15'd0, a[4:0], d[11:0]};
  endfunction

  function automatic logic [31:0] mp(input int a, input int d);
    return {16'd0, a[7:0], d[7:0]};
  endfunction

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.inst_we) begin
        n_checks++;
        if (inst_q.size() == 0) begin
          n_errors++;
          $display("FAIL inst_write_unexpected: got addr=%0d data=%h, none expected",
                   ifc.inst_addr, ifc.inst_wdata);
        end else begin
          mon_exp = inst_q.pop_front();
          if ({ifc.inst_addr, ifc.inst_wdata} !== mon_exp[16:0]) begin
            n_errors++;
            $display("FAIL inst_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     ifc.inst_addr, ifc.inst_wdata, mon_exp[16:12], mon_exp[11:0]);
          end
        end
      end
      if (ifc.mem_we) begin
        n_checks++;
        mem_stamp.push_back(cyc);
        if (mem_q.size() == 0) begin
          n_errors++;
          $display("FAIL mem_write_unexpected: got addr=%h data=%h, none expected",
                   ifc.mem_addr, ifc.mem_wdata);
        end else begin
          mon_exp = mem_q.pop_front();
          if ({ifc.mem_addr, ifc.mem_wdata} !== mon_exp[15:0]) begin
            n_errors++;
            $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                     ifc.mem_addr, ifc.mem_wdata, mon_exp[15:8], mon_exp[7:0]);
          end
        end
      end
    end
  end

  // Drive one byte with up to maxb random bubbles in front; returns on the
  // falling edge before the accepting rising edge.
  task automatic send(input logic [7:0] b, input int maxb);
    int nb;
    int g;
    nb = (maxb > 0) ? $urandom_range(maxb, 0) : 0;
    repeat (nb) begin
      @(negedge clk);
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'($urandom);
    end
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    g = 0;
    while (!ifc.in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%b expected 1", b, ifc.in_ready);
    end
  endtask

  task automatic send_q(input int maxb);
    foreach (bq[i]) send(bq[i], maxb);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({ifc.in_ready, ifc.inst_we, ifc.inst_addr, ifc.inst_wdata, ifc.mem_we,
         ifc.mem_addr, ifc.mem_wdata, ifc.cpu_rstn, ifc.done, ifc.err} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: ready=%b iwe=%b ia=%h iw=%h mwe=%b ma=%h mw=%h rstn=%b done=%b err=%b, expected all 0",
               ifc.in_ready, ifc.inst_we, ifc.inst_addr, ifc.inst_wdata, ifc.mem_we,
               ifc.mem_addr, ifc.mem_wdata, ifc.cpu_rstn, ifc.done, ifc.err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ifc.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_before_edge: got %b expected 0", ifc.in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ifc.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_edge: got %b expected 1", ifc.in_ready);
    end
  endtask

  task automatic test_data();
    mem_stamp.delete();
    mem_q.push_back(mp(8'h10, 8'hAA));
    mem_q.push_back(mp(8'h11, 8'hBB));
    mem_q.push_back(mp(8'h12, 8'hCC));
    bq = {8'h02, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_q(0);
    idle(4);
    n_checks++;
    if (mem_q.size() != 0) begin
      n_errors++;
      $display("FAIL data_writes_pending: got %0d left, expected 0", mem_q.size());
    end
    n_checks++;
    if (mem_stamp.size() != 3 || (mem_stamp[1] - mem_stamp[0]) != 1 || (mem_stamp[2] - mem_stamp[1]) != 1) begin
      n_errors++;
      $display("FAIL data_back_to_back: got %0d strobes not on consecutive cycles, expected 3 consecutive",
               mem_stamp.size());
    end
    n_checks++;
    if (ifc.err !== 1'b0) begin
      n_errors++;
      $display("FAIL data_err: got %b expected 0", ifc.err);
    end
  endtask

  task automatic test_inst();
    inst_q.push_back(ip(0, 12'hFFF));
    inst_q.push_back(ip(1, 12'h123));
    bq = {8'h01, 8'h00, 8'h02, 8'h0F, 8'hFF, 8'h01, 8'h23};
    send_q(0);
    idle(4);
    n_checks++;
    if (inst_q.size() != 0) begin
      n_errors++;
      $display("FAIL inst_writes_pending: got %0d left, expected 0", inst_q.size());
    end
    n_checks++;
    if (ifc.inst_we !== 1'b0 || ifc.err !== 1'b0) begin
      n_errors++;
      $display("FAIL inst_idle: got we=%b err=%b expected we=0 err=0", ifc.inst_we, ifc.err);
    end
  endtask

  task automatic test_range();
    inst_q.push_back(ip(19, 12'hBCD));
    bq = {8'h01, 8'h13, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    send_q(0);
    idle(4);
    n_checks++;
    if (ifc.err !== 1'b1 || inst_q.size() != 0) begin
      n_errors++;
      $display("FAIL inst_range: got err=%b pending=%0d expected err=1 pending=0", ifc.err, inst_q.size());
    end
    do_reset();
    #1;
    n_checks++;
    if (ifc.err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_cleared_by_reset: got %b expected 0", ifc.err);
    end
    mem_q.push_back(mp(8'hFF, 8'h11));
    bq = {8'h02, 8'hFF, 8'h02, 8'h11, 8'h22};
    send_q(0);
    idle(3);
    n_checks++;
    if (ifc.err !== 1'b1) begin
      n_errors++;
      $display("FAIL data_range_err: got %b expected 1", ifc.err);
    end
    mem_q.push_back(mp(8'h20, 8'h5A));
    bq = {8'h02, 8'h20, 8'h01, 8'h5A};
    send_q(0);
    idle(3);
    n_checks++;
    if (mem_q.size() != 0 || ifc.err !== 1'b1) begin
      n_errors++;
      $display("FAIL range_then_record: got pending=%0d err=%b expected pending=0 err=1", mem_q.size(), ifc.err);
    end
  endtask

  task automatic test_flow();
    do_reset();
    mem_q.push_back(mp(8'h10, 8'hAA));
    mem_q.push_back(mp(8'h11, 8'hBB));
    mem_q.push_back(mp(8'h12, 8'hCC));
    bq = {8'h02, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_q(3);
    idle(3);
    n_checks++;
    if (mem_q.size() != 0 || ifc.err !== 1'b0) begin
      n_errors++;
      $display("FAIL flow_data: got pending=%0d err=%b expected pending=0 err=0", mem_q.size(), ifc.err);
    end
    // Long stall between the high and low byte of a word; no write may occur
    // until the low byte arrives (the monitor rejects any early strobe).
    bq = {8'h01, 8'h04, 8'h01, 8'h0A};
    send_q(0);
    idle(6);
    inst_q.push_back(ip(4, 12'hABC));
    send(8'hBC, 0);
    idle(3);
    n_checks++;
    if (inst_q.size() != 0 || ifc.err !== 1'b0) begin
      n_errors++;
      $display("FAIL flow_inst_hold: got pending=%0d err=%b expected pending=0 err=0", inst_q.size(), ifc.err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_q.push_back(mp(8'h30, 8'h11));
    bq = {8'h02, 8'h30, 8'h02, 8'h11};
    send_q(0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #1;
    n_checks++;
    if (ifc.mem_addr !== 8'h30 || mem_q.size() != 0) begin
      n_errors++;
      $display("FAIL mid_first_byte: got addr=%h pending=%0d expected addr=30 pending=0", ifc.mem_addr, mem_q.size());
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ifc.in_ready, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.err, ifc.done} !== '0) begin
      n_errors++;
      $display("FAIL mid_async_reset: got ready=%b we=%b addr=%h data=%h err=%b done=%b expected all 0",
               ifc.in_ready, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.err, ifc.done);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_q.push_back(mp(8'h40, 8'h77));
    bq = {8'h02, 8'h40, 8'h01, 8'h77};
    send_q(0);
    idle(3);
    n_checks++;
    if (mem_q.size() != 0 || ifc.err !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_fresh_record: got pending=%0d err=%b expected pending=0 err=0", mem_q.size(), ifc.err);
    end
  endtask

  task automatic test_go();
    do_reset();
    bq = {8'h7E};
    send_q(0);
    idle(3);
    n_checks++;
    if (ifc.err !== 1'b1) begin
      n_errors++;
      $display("FAIL bad_type_err: got %b expected 1", ifc.err);
    end
    bq = {8'h02, 8'h05, 8'h00};
    send_q(0);
    idle(2);
    send(8'h03, 0);
    n_checks++;
    if (ifc.done !== 1'b0 || ifc.cpu_rstn !== 1'b0 || ifc.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL go_before: got done=%b rstn=%b ready=%b expected 0 0 1", ifc.done, ifc.cpu_rstn, ifc.in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ifc.done !== 1'b1 || ifc.cpu_rstn !== 1'b1 || ifc.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL go_after: got done=%b rstn=%b ready=%b expected 1 1 0", ifc.done, ifc.cpu_rstn, ifc.in_ready);
    end
    // Bytes offered in RUN must be ignored.
    bq = {8'h02, 8'h00, 8'h01, 8'h55};
    foreach (bq[i]) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = bq[i];
    end
    idle(4);
    n_checks++;
    if (ifc.done !== 1'b1 || ifc.cpu_rstn !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.err !== 1'b1) begin
      n_errors++;
      $display("FAIL run_absorbing: got done=%b rstn=%b ready=%b err=%b expected 1 1 0 1",
               ifc.done, ifc.cpu_rstn, ifc.in_ready, ifc.err);
    end
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    test_reset();
    test_data();
    test_inst();
    test_range();
    test_flow();
    test_reset_mid();
    test_go();
    n_checks++;
    if (inst_q.size() != 0 || mem_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_queues: got inst=%0d mem=%0d pending, expected 0 0", inst_q.size(), mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
